ahb_sram_slave: RTL and testbench

AHB-Lite slave wrapping a word-organised on-chip SRAM. It consumes the address/control and write-data phases driven by ahb_master and returns HRDATA/HREADY/HRESP. Wait-state latency is programmable, and it issues protocol-correct two-cycle ERROR responses. It is the downstream memory target on the shared AHB bus and replaces the behavioural slave in system benches.

---
 rtl/ahb_pkg.sv | 47 ++++
 rtl/ahb_sram_array.sv | 30 +++
 rtl/ahb_sram_slave.sv | 134 +++++++++++++
 tb/tb_ahb_sram_slave.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// AHB-Lite shared types, size/burst encodings and the byte-lane helper.
`default_nettype none

package ahb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [1:0] {
      OKAY  = 2'b00,
      ERROR = 2'b01,
      RETRY = 2'b10,
      SPLIT = 2'b11
   } hresp_t;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   // Little-endian lane mask; illegal sizes enable no lanes.
   function automatic logic [3:0] be_from_size(input logic [2:0] size, input logic [1:0] a);
      logic [3:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << a;
         HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: be = 4'b1111;
         default:    be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_sram_array.sv
// Single-port word SRAM: byte-enabled synchronous write, asynchronous read.
`default_nettype none

module ahb_sram_array #(
   parameter int MEM_WORDS = 1024,
   parameter int AW        = $clog2(MEM_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

`default_nettype wire

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and two-cycle ERROR responses.
`default_nettype none

module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int          MEM_WORDS   = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_STATES = 1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [31:0] HWDATA,
   output logic        HREADY,
   output logic [31:0] HRDATA,
   output logic [1:0]  HRESP
);

   localparam int AW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

   state_t        state;
   hresp_t        resp;
   logic [2:0]    cnt;
   logic          pend;
   logic          p_write;
   logic [AW-1:0] p_idx;
   logic [3:0]    p_be;
   logic [31:0]   rd_hold;
   logic [31:0]   mem_rd;

   logic [32:0]   offset;
   logic          accept, out_of_range, bad_size, misaligned, err;
   logic          complete, wr_en;
   logic          unused_burst;

   // Borrow out of the 33-bit subtraction flags addresses below the window.
   assign offset       = {1'b0, HADDR} - {1'b0, BASE_ADDR};
   assign out_of_range = offset[32] || (offset[31:0] >= 32'(4 * MEM_WORDS));
   assign bad_size     = HSIZE > HSIZE_WORD;
   assign misaligned   = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                         ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
   assign err          = out_of_range || bad_size || misaligned;
   assign accept       = HSEL && HREADY &&
                         ((htrans_t'(HTRANS) == NONSEQ) || (htrans_t'(HTRANS) == SEQ));

   assign complete     = HREADY && pend;
   assign wr_en        = complete && p_write && !HRESET;
   assign unused_burst = ^HBURST;

   ahb_sram_array #(.MEM_WORDS(MEM_WORDS)) u_array (
      .clk   (HCLK),
      .we    (wr_en),
      .be    (p_be),
      .addr  (p_idx),
      .wdata (HWDATA),
      .rdata (mem_rd)
   );

   // The async array read makes a write completing on the previous edge visible here.
   assign HRDATA = (complete && !p_write) ? mem_rd : rd_hold;
   assign HRESP  = resp;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state   <= S_IDLE;
         HREADY  <= 1'b1;
         resp    <= OKAY;
         cnt     <= 3'd0;
         pend    <= 1'b0;
         p_write <= 1'b0;
         p_idx   <= '0;
         p_be    <= 4'b0000;
         rd_hold <= 32'h0;
      end else begin
         if (complete && !p_write) rd_hold <= mem_rd;
         if (accept) begin
            p_write <= HWRITE;
            p_idx   <= offset[AW+1:2];
            p_be    <= be_from_size(HSIZE, HADDR[1:0]);
         end
         case (state)
            S_IDLE, S_ERR2: begin
               if (accept && err) begin
                  state  <= S_ERR1;
                  HREADY <= 1'b0;
                  resp   <= ERROR;
                  pend   <= 1'b0;
               end else if (accept && (WAIT_STATES != 0)) begin
                  state  <= S_WAIT;
                  HREADY <= 1'b0;
                  resp   <= OKAY;
                  cnt    <= 3'(WAIT_STATES - 1);
                  pend   <= 1'b1;
               end else begin
                  state  <= S_IDLE;
                  HREADY <= 1'b1;
                  resp   <= OKAY;
                  pend   <= accept;
               end
            end
            S_WAIT: begin
               if (cnt == 3'd0) begin
                  state  <= S_IDLE;
                  HREADY <= 1'b1;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            S_ERR1: begin
               state  <= S_ERR2;
               HREADY <= 1'b1;
               resp   <= ERROR;
            end
            default: begin
               state  <= S_IDLE;
               HREADY <= 1'b1;
               resp   <= OKAY;
               pend   <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
// Randomised bench for ahb_sram_slave: two instances (1 and 0 wait states) against a transfer-level model.
`default_nettype none

module tb_ahb_sram_slave;

   typedef struct {
      bit        sel;
      bit [1:0]  trans;
      bit        write;
      bit [2:0]  size;
      bit [2:0]  burst;
      bit [31:0] addr;
      bit [31:0] data;
   } xfer_t;

   // kind: 0 = no transfer, 1 = OKAY transfer, 2 = ERROR transfer
   typedef struct {
      int        kind;
      bit        write;
      int        idx;
      bit [3:0]  be;
      bit [31:0] data;
      int        k;
   } dphase_t;

   int checks   = 0;
   int failures = 0;
   int n_done   = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(int ws, string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL ws%0d_%s got=%h exp=%h at %0t", ws, nm, got, exp, $time);
      end
   endfunction

   function automatic bit is_err(xfer_t a);
      return (a.addr >= 32'h1000) || (a.size > 3'd2) ||
             ((a.size == 3'd1) && a.addr[0]) ||
             ((a.size == 3'd2) && (a.addr[1:0] != 2'b00));
   endfunction

   function automatic bit [3:0] lanes(xfer_t a);
      bit [3:0] be;
      case (a.size)
         3'd0:    be = 4'b0001 << a.addr[1:0];
         3'd1:    be = a.addr[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      localparam int WS = (gi == 0) ? 1 : 0;

      logic        rst, sel, wr, rdy;
      logic [1:0]  trans, resp;
      logic [2:0]  size, burst;
      logic [31:0] addr, wdata, rdata;

      ahb_sram_slave #(
         .MEM_WORDS   (1024),
         .BASE_ADDR   (32'h0000_0000),
         .WAIT_STATES (WS)
      ) u_dut (
         .HCLK   (clk),
         .HRESET (rst),
         .HSEL   (sel),
         .HADDR  (addr),
         .HTRANS (trans),
         .HWRITE (wr),
         .HSIZE  (size),
         .HBURST (burst),
         .HWDATA (wdata),
         .HREADY (rdy),
         .HRDATA (rdata),
         .HRESP  (resp)
      );

      bit [31:0] mem_m [1024];
      bit        known [1024];
      xfer_t     q [$];
      dphase_t   cur;
      bit [31:0] last_rd;
      bit        last_known;
      bit [31:0] dut_last_rd;
      int        low_cnt;
      bit        rst_req;

      task automatic push(bit s, bit [1:0] t, bit w, bit [2:0] sz, bit [31:0] a, bit [31:0] d, bit [2:0] b);
         xfer_t x;
         x.sel = s; x.trans = t; x.write = w; x.size = sz; x.addr = a; x.data = d; x.burst = b;
         q.push_back(x);
      endtask

      // One bus cycle: drive after the edge, compare at negedge, advance the model at the edge.
      task automatic cycle();
         xfer_t a;
         bit    exp_rdy;
         bit [1:0] exp_resp;
         a = '{default: 0};
         if (q.size() > 0) a = q[0];
         sel   = a.sel;   trans = a.trans; wr    = a.write;
         size  = a.size;  burst = a.burst; addr  = a.addr;
         wdata = cur.data;
         rst   = rst_req;
         @(negedge clk);
         case (cur.kind)
            1:       begin exp_rdy = (cur.k == WS); exp_resp = 2'b00; end
            2:       begin exp_rdy = (cur.k == 1);  exp_resp = 2'b01; end
            default: begin exp_rdy = 1'b1;          exp_resp = 2'b00; end
         endcase
         chk(WS, "hready", {31'h0, rdy}, {31'h0, exp_rdy});
         chk(WS, "hresp", {30'h0, resp}, {30'h0, exp_resp});
         if (!rdy) low_cnt++;
         if (cur.kind == 1 && !cur.write && exp_rdy) begin
            if (known[cur.idx]) chk(WS, "hrdata_read", rdata, mem_m[cur.idx]);
            dut_last_rd = rdata;
         end else if (last_known) begin
            chk(WS, "hrdata_hold", rdata, last_rd);
         end
         @(posedge clk);
         if (rst_req) begin
            cur        = '{default: 0};
            last_rd    = 32'h0;
            last_known = 1'b1;
         end else if (exp_rdy) begin
            if (cur.kind == 1) begin
               if (cur.write) begin
                  for (int b = 0; b < 4; b++)
                     if (cur.be[b]) mem_m[cur.idx][8*b +: 8] = cur.data[8*b +: 8];
                  if (cur.be == 4'hF) known[cur.idx] = 1'b1;
               end else begin
                  last_rd    = mem_m[cur.idx];
                  last_known = known[cur.idx];
               end
            end
            if (q.size() > 0) void'(q.pop_front());
            cur = '{default: 0};
            if (a.sel && a.trans[1]) begin
               cur.kind  = is_err(a) ? 2 : 1;
               cur.write = a.write;
               cur.idx   = int'(a.addr[11:2]);
               cur.be    = lanes(a);
               cur.data  = a.data;
            end
         end else begin
            cur.k++;
         end
         #1;
      endtask

      task automatic run_all();
         for (int n = 0; n < 4000 && (q.size() > 0 || cur.kind != 0); n++) cycle();
         chk(WS, "drain_timeout", {31'h0, (q.size() > 0 || cur.kind != 0)}, 32'h0);
      endtask

      initial begin
         cur = '{default: 0};
         rst_req = 1'b0; last_known = 1'b0; low_cnt = 0;
         rst = 1'b1; sel = 1'b0; trans = 2'b00; wr = 1'b0;
         size = 3'd0; burst = 3'd0; addr = 32'h0; wdata = 32'h0;
         repeat (2) @(posedge clk);
         #1 rst = 1'b0;
         last_rd = 32'h0; last_known = 1'b1;
         @(negedge clk);
         chk(WS, "reset_hready", {31'h0, rdy}, 32'h1);
         chk(WS, "reset_hresp", {30'h0, resp}, 32'h0);
         chk(WS, "reset_hrdata", rdata, 32'h0);
         @(posedge clk); #1;

         // word write then read back
         low_cnt = 0;
         push(1, 2'b10, 1, 3'd2, 32'h100, 32'h1234_5678, 3'd0);
         push(1, 2'b10, 0, 3'd2, 32'h100, 32'h0, 3'd0);
         run_all();
         chk(WS, "word_rd", dut_last_rd, 32'h1234_5678);
         chk(WS, "word_lat", low_cnt, 2 * WS);

         // byte write into lane 3
         push(1, 2'b10, 1, 3'd0, 32'h103, 32'hAB00_0000, 3'd0);
         push(1, 2'b10, 0, 3'd2, 32'h100, 32'h0, 3'd0);
         run_all();
         chk(WS, "byte_rd", dut_last_rd, 32'hAB34_5678);
         chk(WS, "byte_model", mem_m[32'h40], 32'hAB34_5678);

         // out-of-range read: two-cycle error
         low_cnt = 0;
         push(1, 2'b10, 0, 3'd2, 32'h1000, 32'h0, 3'd0);
         run_all();
         chk(WS, "oor_lat", low_cnt, 1);

         // misaligned write errors and leaves memory alone
         push(1, 2'b10, 1, 3'd2, 32'h102, 32'hDEAD_BEEF, 3'd0);
         push(1, 2'b10, 0, 3'd2, 32'h100, 32'h0, 3'd0);
         run_all();
         chk(WS, "misalign_rd", dut_last_rd, 32'hAB34_5678);

         // INCR4 write then INCR4 read
         for (int i = 0; i < 4; i++)
            push(1, (i == 0) ? 2'b10 : 2'b11, 1, 3'd2, 32'h200 + 4*i, i + 1, 3'd3);
         run_all();
         low_cnt = 0;
         for (int i = 0; i < 4; i++)
            push(1, (i == 0) ? 2'b10 : 2'b11, 0, 3'd2, 32'h200 + 4*i, 32'h0, 3'd3);
         run_all();
         chk(WS, "incr4_lat", low_cnt, 4 * WS);
         chk(WS, "incr4_last", dut_last_rd, 32'h4);

         // reset during a pending write aborts it
         push(1, 2'b10, 1, 3'd2, 32'h300, 32'h55AA_55AA, 3'd0);
         run_all();
         push(1, 2'b10, 1, 3'd2, 32'h300, 32'h1111_1111, 3'd0);
         for (int n = 0; n < 50 && !(cur.kind == 1 && cur.write); n++) cycle();
         rst_req = 1'b1;
         cycle();
         rst_req = 1'b0;
         push(1, 2'b10, 0, 3'd2, 32'h300, 32'h0, 3'd0);
         run_all();
         chk(WS, "rst_abort_rd", dut_last_rd, 32'h55AA_55AA);

         // randomised traffic over a prefilled window
         for (int i = 0; i < 16; i++)
            push(1, 2'b10, 1, 3'd2, 32'h400 + 4*i, $urandom, 3'd0);
         for (int i = 0; i < 300; i++) begin
            bit        s, w;
            bit [1:0]  t, off;
            bit [2:0]  sz;
            bit [31:0] a;
            s  = ($urandom_range(0, 9) != 0);
            t  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(2, 3));
            w  = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            off = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) != 0)
               off = off & ((sz == 3'd1) ? 2'b10 : (sz == 3'd2) ? 2'b00 : 2'b11);
            a = 32'h400 + ($urandom_range(0, 15) << 2) + off;
            if ($urandom_range(0, 11) == 0) a = 32'h1000 + $urandom_range(0, 32'hFFFF);
            push(s, t, w, sz, a, $urandom, 3'($urandom_range(0, 7)));
         end
         run_all();
         n_done++;
      end
   end

   initial begin
      for (int t = 0; t < 60000 && n_done < 2; t++) @(posedge clk);
      if (n_done < 2) begin
         failures++;
         $display("FAIL bench_timeout got=%0d exp=2", n_done);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
